// File: rtl/cpu_div_cell.sv
// cpu_div_cell: iterative radix-2 restoring divider for the CPU E/M stages.
// Serves div, divu and remainder. Operands are captured on E_div_start in IDLE,
// one quotient bit is produced per clock, and the result is returned with a
// single-cycle done pulse. Divide by zero bypasses the iteration entirely.
module cpu_div_cell #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] E_src1,
  input  logic [WIDTH-1:0] E_src2,
  input  logic             E_div_start,
  input  logic             E_div_signed,
  input  logic             E_div_rem,
  output logic             M_div_busy,
  output logic             M_div_done,
  output logic [WIDTH-1:0] M_div_result,
  output logic             M_div_by_zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // rem_q: partial remainder; quo_q: dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             sel_rem_q, sel_rem_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic             by_zero_q, by_zero_d;
  logic [WIDTH-1:0] result_q, result_d;

  // Operand magnitudes. The most negative value maps onto itself, which is
  // exactly the right unsigned magnitude 2^(WIDTH-1).
  logic [WIDTH-1:0] src1_mag, src2_mag;
  logic             src1_neg, src2_neg;

  assign src1_neg = E_div_signed & E_src1[WIDTH-1];
  assign src2_neg = E_div_signed & E_src2[WIDTH-1];
  assign src1_mag = src1_neg ? (~E_src1 + ONE_W) : E_src1;
  assign src2_mag = src2_neg ? (~E_src2 + ONE_W) : E_src2;

  // One restoring step: the trial subtraction is one bit wider than the
  // operands so its MSB acts as the borrow / "negative" flag.
  logic [WIDTH:0]   rem_sh, trial;
  logic             trial_neg;

  assign rem_sh    = {rem_q, quo_q[WIDTH-1]};
  assign trial     = rem_sh - {1'b0, dvs_q};
  assign trial_neg = trial[WIDTH];

  // Sign fix-up of the final magnitudes.
  logic [WIDTH-1:0] q_fix, r_fix;

  assign q_fix = negq_q ? (~quo_q + ONE_W) : quo_q;
  assign r_fix = negr_q ? (~rem_q + ONE_W) : rem_q;

  // Next-state, datapath and output computation for the IDLE/RUN/FIXUP sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    sel_rem_d = sel_rem_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    by_zero_d = 1'b0;
    result_d  = result_q;

    case (state_q)
      IDLE: begin
        if (E_div_start) begin
          sel_rem_d = E_div_rem;
          if (E_src2 == '0) begin
            // Divide by zero: preload the architectural answers so FIXUP
            // can emit them through the normal path with no sign change.
            state_d = FIXUP;
            quo_d   = '1;
            rem_d   = E_src1;
            dvs_d   = '0;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            dz_d    = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = RUN;
            quo_d   = src1_mag;
            dvs_d   = src2_mag;
            rem_d   = '0;
            negq_d  = src1_neg ^ src2_neg;
            negr_d  = src1_neg;
            dz_d    = 1'b0;
            cnt_d   = CNT_LAST;
          end
        end
      end

      RUN: begin
        if (trial_neg) begin
          rem_d = rem_sh[WIDTH-1:0];
        end else begin
          rem_d = trial[WIDTH-1:0];
        end
        quo_d = {quo_q[WIDTH-2:0], ~trial_neg};
        cnt_d = cnt_q - ONE_C;
        if (cnt_q == '0) begin
          state_d = FIXUP;
        end
      end

      FIXUP: begin
        result_d  = sel_rem_q ? r_fix : q_fix;
        done_d    = 1'b1;
        by_zero_d = dz_q;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      sel_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      by_zero_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      sel_rem_q <= sel_rem_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
      by_zero_q <= by_zero_d;
      result_q  <= result_d;
    end
  end

  assign M_div_busy    = (state_q != IDLE);
  assign M_div_done    = done_q;
  assign M_div_result  = result_q;
  assign M_div_by_zero = by_zero_q;

endmodule

// File: tb/tb_cpu_div_cell.sv
// Bench for cpu_div_cell: directed vectors with literal expectations plus an
// arithmetic reference model checked against the DUT on every cycle.
module tb_cpu_div_cell;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] E_src1, E_src2;
  logic         E_div_start, E_div_signed, E_div_rem;
  logic         M_div_busy, M_div_done, M_div_by_zero;
  logic [W-1:0] M_div_result;

  always #5 clk = ~clk;

  cpu_div_cell #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset),
    .E_src1(E_src1), .E_src2(E_src2),
    .E_div_start(E_div_start), .E_div_signed(E_div_signed), .E_div_rem(E_div_rem),
    .M_div_busy(M_div_busy), .M_div_done(M_div_done),
    .M_div_result(M_div_result), .M_div_by_zero(M_div_by_zero)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: 64-bit signed division truncates toward zero and
  // gives the remainder the dividend's sign; the low W bits are the answer.
  function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input bit sg, input bit rm);
    longint sa, sb, q, r;
    if (b == '0) return rm ? a : '1;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return rm ? r[W-1:0] : q[W-1:0];
  endfunction

  // Transaction-level model: an accepted start completes a fixed number of
  // edges later; starts while busy are dropped.
  bit           m_busy, m_done, m_bz, m_pend_bz;
  int           m_cnt;
  logic [W-1:0] m_res, m_pend;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_bz = 0; m_cnt = 0; m_res = '0;
    end else begin
      m_done = 0; m_bz = 0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 0; m_done = 1; m_bz = m_pend_bz; m_res = m_pend;
        end
      end else if (E_div_start) begin
        m_pend    = ref_div(E_src1, E_src2, E_div_signed, E_div_rem);
        m_pend_bz = (E_src2 == '0);
        m_cnt     = (E_src2 == '0) ? 1 : W + 1;
        m_busy    = 1;
      end
    end
  end

  // Compare DUT against the model mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", W'(M_div_busy), W'(m_busy));
      chk("model_done", W'(M_div_done), W'(m_done));
      chk("model_result", M_div_result, m_res);
      chk("model_by_zero", W'(M_div_by_zero), W'(m_bz));
    end
  end

  // Issue one operation, optionally re-pulse start at cycles p1/p2, wait for
  // done and check latency, result and by_zero against literals.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit sg, input bit rm, input logic [W-1:0] exp_res,
                        input int exp_lat, input bit exp_bz, input int p1, input int p2);
    int n;
    bit got;
    @(negedge clk);
    E_src1 = a; E_src2 = b; E_div_signed = sg; E_div_rem = rm; E_div_start = 1'b1;
    n = 0; got = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (M_div_done) got = 1;
      E_div_start = !got && (n == p1 || n == p2);
      // Scramble inputs after the start edge; they must have no effect.
      E_src1 = $urandom; E_src2 = $urandom_range(1, 50); E_div_signed = $urandom_range(0, 1);
      E_div_rem = $urandom_range(0, 1);
    end
    E_div_start = 1'b0;
    chk({name, "_seen"}, W'(got), W'(1));
    chk({name, "_latency"}, W'(n), W'(exp_lat));
    chk({name, "_result"}, M_div_result, exp_res);
    chk({name, "_by_zero"}, W'(M_div_by_zero), W'(exp_bz));
  endtask

  initial begin
    int n;
    bit got;
    reset = 1'b1; E_src1 = '0; E_src2 = '0;
    E_div_start = 1'b0; E_div_signed = 1'b0; E_div_rem = 1'b0;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_busy", W'(M_div_busy), W'(0));
    chk("reset_done", W'(M_div_done), W'(0));
    chk("reset_result", M_div_result, '0);
    chk("reset_by_zero", W'(M_div_by_zero), W'(0));
    reset = 1'b0;

    run_op("u100d7_q", 32'd100, 32'd7, 0, 0, 32'd14, 34, 0, -1, -1);
    run_op("u100d7_r", 32'd100, 32'd7, 0, 1, 32'd2, 34, 0, -1, -1);
    run_op("sm100d7_q", 32'hFFFFFF9C, 32'd7, 1, 0, 32'hFFFFFFF2, 34, 0, -1, -1);
    run_op("sm100d7_r", 32'hFFFFFF9C, 32'd7, 1, 1, 32'hFFFFFFFE, 34, 0, -1, -1);
    run_op("s100dm7_q", 32'd100, 32'hFFFFFFF9, 1, 0, 32'hFFFFFFF2, 34, 0, -1, -1);
    run_op("s100dm7_r", 32'd100, 32'hFFFFFFF9, 1, 1, 32'd2, 34, 0, -1, -1);
    run_op("dz_q", 32'h12345678, 32'd0, 0, 0, 32'hFFFFFFFF, 2, 1, -1, -1);
    run_op("dz_r", 32'h12345678, 32'd0, 0, 1, 32'h12345678, 2, 1, -1, -1);
    run_op("dz_sr", 32'h87654321, 32'd0, 1, 1, 32'h87654321, 2, 1, -1, -1);
    run_op("ovf_q", 32'h80000000, 32'hFFFFFFFF, 1, 0, 32'h80000000, 34, 0, -1, -1);
    run_op("ovf_r", 32'h80000000, 32'hFFFFFFFF, 1, 1, 32'd0, 34, 0, -1, -1);
    run_op("umax_d1", 32'hFFFFFFFF, 32'd1, 0, 0, 32'hFFFFFFFF, 34, 0, -1, -1);
    run_op("u_big", 32'hFFFFFFFF, 32'h80000000, 0, 1, 32'h7FFFFFFF, 34, 0, -1, -1);

    // Start pulses during the operation are ignored: one done, same answer.
    run_op("busy_start", 32'd1000, 32'd9, 0, 0, 32'd111, 34, 0, 5, 20);
    repeat (40) @(negedge clk);

    // Start held through done: second op accepted in the done cycle.
    @(negedge clk);
    E_src1 = 32'd100; E_src2 = 32'd7; E_div_signed = 0; E_div_rem = 0; E_div_start = 1'b1;
    n = 0; got = 0;
    while (!got && n < 100) begin
      @(negedge clk); n++;
      if (M_div_done) got = 1;
    end
    chk("hold_first_latency", W'(n), W'(34));
    chk("hold_first_result", M_div_result, 32'd14);
    E_src1 = 32'd9; E_src2 = 32'd3;
    @(negedge clk);
    E_div_start = 1'b0;
    chk("hold_second_busy", W'(M_div_busy), W'(1));
    chk("hold_result_kept", M_div_result, 32'd14);
    n = 1; got = 0;
    while (!got && n < 100) begin
      @(negedge clk); n++;
      if (M_div_done) got = 1;
    end
    chk("hold_second_latency", W'(n), W'(34));
    chk("hold_second_result", M_div_result, 32'd3);

    // Reset mid-RUN aborts without a done; a following op runs normally.
    @(negedge clk);
    E_src1 = 32'd5000; E_src2 = 32'd13; E_div_start = 1'b1;
    @(negedge clk);
    E_div_start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", W'(M_div_busy), W'(0));
    chk("abort_result", M_div_result, '0);
    got = 0;
    repeat (40) begin
      @(negedge clk);
      if (M_div_done) got = 1;
    end
    chk("abort_no_done", W'(got), W'(0));
    run_op("after_reset", 32'd9, 32'd3, 0, 0, 32'd3, 34, 0, -1, -1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
